iter_muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit for the RV32M extension. Sits beside the single-cycle ALU in the execute stage.
- Width is a parameter, so the same block serves 32- and 64-bit datapaths.
- Radix-2 iterative engine with valid/ready handshakes on input and output.
- Decode stalls the pipeline while busy is high.

---
 rtl/iter_muldiv_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_iter_muldiv_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv_unit.sv
// Radix-2 iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Optional last-divide result cache: define MULDIV_OPCACHE_EN.
module iter_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   mcand_q;
    logic              neg_q;
    logic              neg_r_q;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              a_signed, b_signed;
    logic              a_s, b_s;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, cache_hit;
    logic              shortcut;
    logic [XLEN-1:0]   short_res;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix;
    logic [XLEN-1:0]   fix_res;

`ifdef MULDIV_OPCACHE_EN
    logic              cache_v;
    logic [XLEN-1:0]   cache_a, cache_b, cache_q, cache_r;
    logic              cache_u;
    logic [XLEN-1:0]   opa_q, opb_q;
`endif

    assign accept    = in_valid && (state_q == IDLE) && !flush;
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

    // Operand signedness by funct3
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        unique case (op)
            3'b001:         begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010:         a_signed = 1'b1;
            3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
            default:        ;
        endcase
    end

    assign a_s   = a_signed & src_a[XLEN-1];
    assign b_s   = b_signed & src_b[XLEN-1];
    assign mag_a = a_s ? -src_a : src_a;
    assign mag_b = b_s ? -src_b : src_b;

    assign div_zero = op[2] && (src_b == '0);
    assign div_ovf  = op[2] && !op[0]
                   && (src_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (src_b == '1);

`ifdef MULDIV_OPCACHE_EN
    assign cache_hit = op[2] && cache_v && (op[0] == cache_u)
                    && (src_a == cache_a) && (src_b == cache_b);
`else
    assign cache_hit = 1'b0;
`endif

    assign shortcut = div_zero || div_ovf || cache_hit;

    always_comb begin
        short_res = '0;
        if (div_zero) begin
            short_res = op[1] ? src_a : '1;
        end else if (div_ovf) begin
            short_res = op[1] ? '0 : src_a;
        end
`ifdef MULDIV_OPCACHE_EN
        else if (cache_hit) begin
            short_res = op[1] ? cache_r : cache_q;
        end
`endif
    end

    // Shift-add: add multiplicand into the high half when the low bit is set
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                    + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide: high half is the partial remainder, low half the quotient
    assign div_diff = {1'b0, acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]}
                    - {2'b00, mcand_q};
    always_comb begin
        if (!div_diff[XLEN+1]) begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {acc_q[2*XLEN-2:0], 1'b0};
        end
    end

    assign prod_fix = neg_q   ? -acc_q                 : acc_q;
    assign q_fix    = neg_q   ? -acc_q[XLEN-1:0]       : acc_q[XLEN-1:0];
    assign r_fix    = neg_r_q ? -acc_q[2*XLEN-1:XLEN]  : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_res = '0;
        unique case (op_q)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = q_fix;
            default:                fix_res = r_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (accept) state_d = shortcut ? DONE : CALC;
                CALC: if (cnt_q == '0) state_d = FIX;
                FIX:  state_d = DONE;
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            op_q    <= op;
            cnt_q   <= CNT_W'(XLEN-1);
            neg_q   <= a_s ^ b_s;
            neg_r_q <= a_s;
            if (op[2]) begin
                acc_q   <= {{XLEN{1'b0}}, mag_a};
                mcand_q <= mag_b;
            end else begin
                acc_q   <= {{XLEN{1'b0}}, mag_b};
                mcand_q <= mag_a;
            end
            if (shortcut) result_q <= short_res;
        end else if (!flush && state_q == CALC) begin
            acc_q <= op_q[2] ? div_next : mul_next;
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end else if (!flush && state_q == FIX) begin
            result_q <= fix_res;
        end
    end

`ifdef MULDIV_OPCACHE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_v <= 1'b0;
            cache_u <= 1'b0;
            cache_a <= '0;
            cache_b <= '0;
            cache_q <= '0;
            cache_r <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else if (flush) begin
            cache_v <= 1'b0;
        end else if (accept) begin
            opa_q <= src_a;
            opb_q <= src_b;
        end else if (state_q == FIX && op_q[2]) begin
            cache_v <= 1'b1;
            cache_u <= op_q[0];
            cache_a <= opa_q;
            cache_b <= opb_q;
            cache_q <= q_fix;
            cache_r <= r_fix;
        end
    end
`endif

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed self-checking bench for iter_muldiv_unit at XLEN=32.
// Build with +define+MULDIV_OPCACHE_EN to check the divide cache latency.
module tb_iter_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      op = 3'b000;
    logic [XLEN-1:0] src_a = '0;
    logic [XLEN-1:0] src_b = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iter_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(op),
        .src_a(src_a),
        .src_b(src_b),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .busy(busy)
    );

    // Issue one op, scramble inputs after accept, wait for and consume the result
    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat);
        @(negedge clk);
        op = o; src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        src_a = 32'h5A5A_1234; src_b = 32'h0F0F_0003; op = 3'b011;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #11;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b busy=%b want 1 0 0",
                     in_ready, out_valid, busy);
        end
        checks++;
        if (result !== 32'h0) begin
            failures++;
            $display("FAIL reset_result: got %h want 0", result);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [2:0]  ops[4] = '{3'b000, 3'b001, 3'b011, 3'b010};
        logic [31:0] as[4]  = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs[4]  = '{32'hFFFFFFFD, 32'hFFFFFFFD,
                                32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ex[4]  = '{32'hFFFFFFEB, 32'hFFFFFFFF,
                                32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] r;
        int l;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], r, l);
            checks++;
            if (r !== ex[i]) begin
                failures++;
                $display("FAIL mul_%0d: got %h want %h", i, r, ex[i]);
            end
            checks++;
            if (l !== 34) begin
                failures++;
                $display("FAIL mul_lat_%0d: got %0d want 34", i, l);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops[5] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100};
        logic [31:0] as[5]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                32'd20};
        logic [31:0] bs[5]  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFB};
        logic [31:0] ex[5]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                                32'hFFFFFFFC};
        logic [31:0] r;
        int l;
        for (int i = 0; i < 5; i++) begin
            // Fresh reset so a cached divide cannot shortcut these
            @(negedge clk) rst_n = 1'b0;
            @(negedge clk) rst_n = 1'b1;
            run_op(ops[i], as[i], bs[i], r, l);
            checks++;
            if (r !== ex[i]) begin
                failures++;
                $display("FAIL div_%0d: got %h want %h", i, r, ex[i]);
            end
            checks++;
            if (l !== 34) begin
                failures++;
                $display("FAIL div_lat_%0d: got %0d want 34", i, l);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops[6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] as[6]  = '{32'd5, 32'd5, 32'd5, 32'd5,
                                32'h80000000, 32'h80000000};
        logic [31:0] bs[6]  = '{32'd0, 32'd0, 32'd0, 32'd0,
                                32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ex[6]  = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd5,
                                32'h80000000, 32'd0};
        logic [31:0] r;
        int l;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], r, l);
            checks++;
            if (r !== ex[i]) begin
                failures++;
                $display("FAIL special_%0d: got %h want %h", i, r, ex[i]);
            end
            checks++;
            if (l !== 1) begin
                failures++;
                $display("FAIL special_lat_%0d: got %0d want 1", i, l);
            end
        end
    endtask

    task automatic test_hold();
        int k;
        @(negedge clk);
        op = 3'b000; src_a = 32'd7; src_b = 32'hFFFFFFFD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; src_a = 32'd9;
        k = 1;
        while (!out_valid && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (k !== 34) begin
            failures++;
            $display("FAIL hold_lat: got %0d want 34", k);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0
                || result !== 32'hFFFFFFEB) begin
                failures++;
                $display("FAIL hold_%0d: got vld=%b rdy=%b res=%h want 1 0 ffffffeb",
                         i, out_valid, in_ready, result);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: got vld=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        int l;
        bit seen = 1'b0;
        @(negedge clk);
        op = 3'b100; src_a = 32'hFFFFFFF9; src_b = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy: got busy=%b rdy=%b want 1 0", busy, in_ready);
        end
        repeat (11) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: got rdy=%b busy=%b vld=%b want 1 0 0",
                     in_ready, busy, out_valid);
        end
        checks++;
        if (result !== 32'hFFFFFFEB) begin
            failures++;
            $display("FAIL flush_keep: got %h want ffffffeb", result);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_valid: got %b want 0", seen);
        end
        run_op(3'b101, 32'd100, 32'd7, r, l);
        checks++;
        if (r !== 32'd14 || l !== 34) begin
            failures++;
            $display("FAIL flush_next: got %h lat %0d want 0000000e lat 34", r, l);
        end
    endtask

    task automatic test_flush_accept();
        @(negedge clk);
        op = 3'b100; src_a = 32'd5; src_b = 32'd0;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_blocks_accept: got busy=%b vld=%b want 0 0",
                     busy, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        int l;
        @(negedge clk);
        op = 3'b001; src_a = 32'd7; src_b = 32'hFFFFFFFD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1
            || result !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: got vld=%b busy=%b rdy=%b res=%h want 0 0 1 0",
                     out_valid, busy, in_ready, result);
        end
        @(negedge clk) rst_n = 1'b1;
        run_op(3'b000, 32'd3, 32'd5, r, l);
        checks++;
        if (r !== 32'd15 || l !== 34) begin
            failures++;
            $display("FAIL reset_mid_next: got %h lat %0d want 0000000f lat 34", r, l);
        end
    endtask

    task automatic test_back_to_back();
        int c1 = -1;
        int c2 = -1;
        int k = 0;
        logic [31:0] r1 = '0;
        @(negedge clk);
        op = 3'b000; src_a = 32'd3; src_b = 32'd5;
        in_valid = 1'b1; out_ready = 1'b1;
        while (c2 < 0 && k < 300) begin
            @(posedge clk); #1;
            k++;
            if (out_valid) begin
                if (c1 < 0) begin
                    c1 = k;
                    r1 = result;
                end else begin
                    c2 = k;
                    in_valid = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (c1 !== 34 || r1 !== 32'd15) begin
            failures++;
            $display("FAIL b2b_first: got cyc %0d res %h want 34 0000000f", c1, r1);
        end
        checks++;
        if (c2 - c1 !== 35) begin
            failures++;
            $display("FAIL b2b_gap: got %0d want 35", c2 - c1);
        end
    endtask

    task automatic test_cache();
        logic [31:0] r;
        int l;
        int want_lat;
`ifdef MULDIV_OPCACHE_EN
        want_lat = 1;
`else
        want_lat = 34;
`endif
        run_op(3'b101, 32'd100, 32'd7, r, l);
        checks++;
        if (r !== 32'd14 || l !== 34) begin
            failures++;
            $display("FAIL cache_first: got %h lat %0d want 0000000e lat 34", r, l);
        end
        run_op(3'b111, 32'd100, 32'd7, r, l);
        checks++;
        if (r !== 32'd2 || l !== want_lat) begin
            failures++;
            $display("FAIL cache_rem: got %h lat %0d want 00000002 lat %0d",
                     r, l, want_lat);
        end
        run_op(3'b001, 32'd100, 32'd7, r, l);
        checks++;
        if (r !== 32'd0 || l !== 34) begin
            failures++;
            $display("FAIL cache_mul_miss: got %h lat %0d want 0 lat 34", r, l);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_hold();
        test_flush();
        test_flush_accept();
        test_reset_mid();
        test_back_to_back();
        test_cache();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
